linebuf_window_ctrl: RTL and testbench
======================================

Name: linebuf_window_ctrl

Overview:
Sequencer for the 3x3 line-buffer window datapath. Accepts a raster pixel stream with valid/ready handshake and drives the line buffer's column/row address and write enable. Emits a window-valid stream tagged with centre coordinates and border flags to the downstream 3x3 filter. Handles one-line prefill, end-of-frame flush, backpressure and stream resynchronisation.

Parameters:
H_ACTIVE, 640, active pixels per line (2..1920)
V_ACTIVE, 480, active lines per frame (3..1080)
CW, 11, coordinate width (x/y buses)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel accepted when s_valid&&s_ready
s_sof  in  1  start of frame, qualifies first pixel of frame
s_eol  in  1  last pixel of line
lb_x  out  CW  line-buffer column address
lb_y  out  CW  line-buffer input row index
lb_we  out  1  line-buffer shift/write strobe
m_valid  out  1  window valid for centre pixel
m_ready  in  1  downstream ready
m_x  out  CW  window centre column
m_y  out  CW  window centre row
m_border  out  4  {top,bottom,left,right}: m_y==0, m_y==V_ACTIVE-1, m_x==0, m_x==H_ACTIVE-1
frame_done  out  1  one-cycle pulse after last window of frame is accepted
err_sync  out  1  sticky; set on EOL mismatch or mid-frame SOF; cleared by reset only

Behaviour:
- Reset: state IDLE; s_ready=0, lb_we=0, m_valid=0, lb_x=lb_y=m_x=m_y=0, m_border=0, frame_done=0, err_sync=0; pipeline valids cleared. Reset mid-frame discards all in-flight windows immediately.
- Pipeline: 2 stages (P1 = address/write cycle, P2 = line-buffer read register). adv = m_ready || !m_valid. Stages shift only when adv. s_ready = adv && state in {FILL,RUN}.
- lb_we = 1 exactly on cycles with s_valid&&s_ready; lb_x = input column counter x_in, lb_y = y_in. lb_x/lb_y hold while stalled.
- Latency: window for a pixel accepted in cycle N (RUN) appears on m_valid in cycle N+2 with no backpressure.
- Centre row lags input by one line: m_y = y_in-1, m_x = x_in.
- States:
  IDLE: s_ready=0 except a pixel with s_valid&&s_sof is accepted -> FILL with x_in=1, y_in=0. Pixels without s_sof in IDLE are dropped (s_ready forced 1 for them, lb_we=0).
  FILL: y_in=0, no windows generated. x_in wraps at H_ACTIVE-1 -> RUN, y_in=1.
  RUN: each accepted pixel enters P1 with centre (x_in, y_in-1). On wrap of line V_ACTIVE-1 -> FLUSH.
  FLUSH: s_ready=0, lb_we=0; internal counter injects H_ACTIVE windows for row V_ACTIVE-1, one per adv cycle. After the last injection -> DRAIN.
  DRAIN: wait until P1/P2 empty; pulse frame_done the cycle after final m_valid&&m_ready; -> IDLE.
- x_in wraps at H_ACTIVE-1 regardless of s_eol. s_eol at x_in!=H_ACTIVE-1, or absent at x_in==H_ACTIVE-1: set err_sync, no other effect.
- s_sof accepted in FILL/RUN: set err_sync, flush P1/P2 (m_valid drops next cycle), restart FILL with that pixel as (0,0). s_sof in FLUSH/DRAIN not accepted (s_ready=0); waits for IDLE.
- Counter arithmetic CW bits, unsigned; no counter exceeds H_ACTIVE-1 / V_ACTIVE-1.

Optional Feature:
LBCTRL_STALL_STATS_EN: defined -> adds output stall_cnt (16 bits): counts cycles with m_valid && !m_ready, saturates at 16'hFFFF, cleared to 0 on reset and on accepted SOF. Undefined -> port and counter absent; all other behaviour identical.

Test Plan:
- H=8,V=4, continuous s_valid, m_ready=1, correct sof/eol -> first m_valid 2 cycles after 9th accepted pixel, m=(0,0) border=4'b1010; 32 windows total, last (7,3) border=4'b0101; frame_done 1 pulse.
- Same, m_ready toggled 1/0 each cycle -> s_ready low whenever m_valid&&!m_ready; 32 windows in raster order, none duplicated or lost; lb_x/lb_y stable while stalled.
- s_eol on x=5 of line 1 -> err_sync=1 next cycle, stays 1; window count still 32, coordinates unchanged.
- s_sof injected at (3,2) -> m_valid deasserts, err_sync=1, next windows restart at (0,0) after one full prefill line.
- Pixels without s_sof in IDLE -> lb_we=0, m_valid=0, no state change; reset asserted during FLUSH -> all outputs at reset values next cycle, frame_done never pulses.

Source files
------------

// File: rtl/linebuf_window_ctrl.sv
// Sequencer for the 3x3 line-buffer window datapath: raster input handshake, line-buffer addressing,
// centre-tagged window stream with border flags. Optional stall counter under LBCTRL_STALL_STATS_EN.
module linebuf_window_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_sof,
  input  logic          s_eol,
  output logic [CW-1:0] lb_x,
  output logic [CW-1:0] lb_y,
  output logic          lb_we,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] m_x,
  output logic [CW-1:0] m_y,
  output logic [3:0]    m_border,
  output logic          frame_done,
  output logic          err_sync
`ifdef LBCTRL_STALL_STATS_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam logic [CW-1:0] X_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_ACTIVE - 1);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] x_in;
  logic [CW-1:0] y_in;
  logic          p1_valid;
  logic [CW-1:0] p1_x;
  logic [CW-1:0] p1_y;

  logic adv;
  logic active;
  logic take;
  logic sof_take;
  logic eol_bad;

  // In IDLE every offered pixel is consumed; only an SOF pixel is written, the rest are dropped.
  always_comb begin
    adv      = m_ready || !m_valid;
    active   = (state == FILL) || (state == RUN);
    s_ready  = 1'b0;
    if (!reset) begin
      if (state == IDLE) s_ready = s_valid;
      else               s_ready = active && adv;
    end
    take     = s_valid && s_ready;
    sof_take = take && s_sof;
    lb_we    = take && ((state != IDLE) || s_sof);
    lb_x     = sof_take ? '0 : x_in;
    lb_y     = sof_take ? '0 : y_in;
    eol_bad  = lb_we && (s_eol != (lb_x == X_LAST));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      x_in       <= '0;
      y_in       <= '0;
      p1_valid   <= 1'b0;
      p1_x       <= '0;
      p1_y       <= '0;
      m_valid    <= 1'b0;
      m_x        <= '0;
      m_y        <= '0;
      m_border   <= '0;
      frame_done <= 1'b0;
      err_sync   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (eol_bad || (sof_take && active)) err_sync <= 1'b1;

      if (adv) begin
        m_valid  <= p1_valid;
        m_x      <= p1_x;
        m_y      <= p1_y;
        m_border <= {p1_y == '0, p1_y == Y_LAST, p1_x == '0, p1_x == X_LAST};
        p1_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sof_take) begin
            state <= FILL;
            x_in  <= CW'(1);
            y_in  <= '0;
          end
        end
        FILL, RUN: begin
          if (sof_take) begin
            // Resynchronise: the SOF pixel becomes (0,0) and every in-flight window is discarded.
            state    <= FILL;
            x_in     <= CW'(1);
            y_in     <= '0;
            p1_valid <= 1'b0;
            m_valid  <= 1'b0;
          end else if (take) begin
            if (state == RUN) begin
              p1_valid <= 1'b1;
              p1_x     <= x_in;
              p1_y     <= y_in - CW'(1);
            end
            if (x_in == X_LAST) begin
              x_in <= '0;
              if (state == FILL) begin
                y_in  <= CW'(1);
                state <= RUN;
              end else if (y_in == Y_LAST) begin
                state <= FLUSH;
              end else begin
                y_in <= y_in + CW'(1);
              end
            end else begin
              x_in <= x_in + CW'(1);
            end
          end
        end
        FLUSH: begin
          // The last row has no line below it; its windows are injected without input pixels.
          if (adv) begin
            p1_valid <= 1'b1;
            p1_x     <= x_in;
            p1_y     <= y_in;
            if (x_in == X_LAST) begin
              x_in  <= '0;
              y_in  <= '0;
              state <= DRAIN;
            end else begin
              x_in <= x_in + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (!p1_valid && m_valid && m_ready) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end else if (!p1_valid && !m_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LBCTRL_STALL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || sof_take)                                  stall_cnt <= '0;
    else if (m_valid && !m_ready && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
  end
`else
  // Stall statistics disabled: no counter is built.
`endif

endmodule

// File: tb/tb_linebuf_window_ctrl.sv
// Self-checking bench for linebuf_window_ctrl (H=8, V=4): randomized pacing against a raster-order window model.
module tb_linebuf_window_ctrl;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int CW = 11;
  localparam int WW = 2 * CW + 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_sof = 1'b0;
  logic          s_eol = 1'b0;
  logic          m_ready = 1'b1;
  logic          s_ready;
  logic [CW-1:0] lb_x;
  logic [CW-1:0] lb_y;
  logic          lb_we;
  logic          m_valid;
  logic [CW-1:0] m_x;
  logic [CW-1:0] m_y;
  logic [3:0]    m_border;
  logic          frame_done;
  logic          err_sync;
`ifdef LBCTRL_STALL_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  int check_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int ninth_cyc = -1;
  int first_win_cyc = -1;
  int done_cnt = 0;
  int rdy_mode = 0;
  logic [WW-1:0] obs_q[$];

  always #5 clk = ~clk;

  linebuf_window_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_eol(s_eol),
    .lb_x(lb_x), .lb_y(lb_y), .lb_we(lb_we),
    .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y), .m_border(m_border),
    .frame_done(frame_done), .err_sync(err_sync)
`ifdef LBCTRL_STALL_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always @(posedge clk) cyc++;

  // Downstream ready pattern: 0 = always ready, 1 = toggling, 2 = random 75% ready.
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = !m_ready;
      default: m_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Observer: collects handshaked windows, accepted-pixel timing and frame_done pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (lb_we) begin
        acc_cnt++;
        if (acc_cnt == H + 1) ninth_cyc = cyc;
      end
      if (m_valid && first_win_cyc < 0) first_win_cyc = cyc;
      if (m_valid && m_ready) obs_q.push_back({m_x, m_y, m_border});
      if (frame_done) done_cnt++;
    end
  end

  function automatic logic [WW-1:0] exp_win(input int i);
    int x = i % H;
    int y = i / H;
    logic [3:0] b = {y == 0, y == V - 1, x == 0, x == H - 1};
    return {CW'(x), CW'(y), b};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    done_cnt = 0;
    acc_cnt = 0;
    ninth_cyc = -1;
    first_win_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_valid = 1'b0;
    s_sof = 1'b0;
    s_eol = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_obs();
  endtask

  // Offers one pixel after an idle gap and waits (bounded) for it to be taken.
  task automatic apply_stimulus(input int x, input int y, input bit sof, input bit eol, input int gap);
    bit accepted = 0;
    s_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_sof = sof;
    s_eol = eol;
    for (int k = 0; k < 200 && !accepted; k++) begin
      @(negedge clk);
      if (m_valid && !m_ready) check_output("stall_ready", s_ready, 0);
      if (s_ready) begin
        check_output("lb_we", lb_we, 1);
        check_output("lb_x", lb_x, x);
        check_output("lb_y", lb_y, y);
        accepted = 1;
      end else if (!sof) begin
        check_output("hold_lb_x", lb_x, x);
        check_output("hold_lb_y", lb_y, y);
        check_output("hold_we", lb_we, 0);
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) check_output("accept_timeout", accepted, 1);
    s_valid = 1'b0;
    s_sof = 1'b0;
    s_eol = 1'b0;
  endtask

  task automatic send_pixels(input int first, input int last, input int max_gap, input int bad_eol);
    for (int i = first; i <= last; i++) begin
      int x = i % H;
      int y = i / H;
      apply_stimulus(x, y, i == 0, (x == H - 1) ^ (i == bad_eol), max_gap > 0 ? $urandom_range(0, max_gap) : 0);
    end
  endtask

  task automatic wait_frame_and_verify();
    for (int k = 0; k < 600 && done_cnt == 0; k++) @(negedge clk);
    repeat (4) @(posedge clk);
    #1;
    check_output("frame_done_pulses", done_cnt, 1);
    check_output("win_count", obs_q.size(), H * V);
    for (int i = 0; i < obs_q.size() && i < H * V; i++)
      check_output($sformatf("win%0d", i), obs_q[i], exp_win(i));
  endtask

  initial begin
    $display("[TB] start");
    do_reset();

    // Reset values
    check_output("rst_s_ready", s_ready, 0);
    check_output("rst_lb_we", lb_we, 0);
    check_output("rst_m_valid", m_valid, 0);
    check_output("rst_lb_x", lb_x, 0);
    check_output("rst_lb_y", lb_y, 0);
    check_output("rst_m_x", m_x, 0);
    check_output("rst_m_y", m_y, 0);
    check_output("rst_border", m_border, 0);
    check_output("rst_frame_done", frame_done, 0);
    check_output("rst_err", err_sync, 0);

    // Pixels without SOF in IDLE are dropped
    s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("idle_drop_ready", s_ready, 1);
      check_output("idle_drop_we", lb_we, 0);
      check_output("idle_drop_mvalid", m_valid, 0);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check_output("idle_drop_count", acc_cnt, 0);

    // Frame 1: continuous input, always ready
    rdy_mode = 0;
    send_pixels(0, H * V - 1, 0, -1);
    wait_frame_and_verify();
    check_output("latency", first_win_cyc - ninth_cyc, 2);
    check_output("clean_err", err_sync, 0);

    // Frame 2: downstream ready toggles every cycle
    clear_obs();
    rdy_mode = 1;
    send_pixels(0, H * V - 1, 0, -1);
    wait_frame_and_verify();

    // Frame 3: random input gaps and random downstream ready
    clear_obs();
    rdy_mode = 2;
    send_pixels(0, H * V - 1, 2, -1);
    wait_frame_and_verify();
    check_output("random_err", err_sync, 0);

    // Misplaced EOL at (5,1): sticky error, stream otherwise unaffected
    rdy_mode = 0;
    do_reset();
    send_pixels(0, H + 4, 0, -1);
    check_output("eol_err_before", err_sync, 0);
    send_pixels(H + 5, H + 5, 0, H + 5);
    check_output("eol_err_set", err_sync, 1);
    send_pixels(H + 6, H * V - 1, 1, -1);
    wait_frame_and_verify();
    check_output("eol_err_sticky", err_sync, 1);

    // Mid-frame SOF where (3,2) would be: pipeline discarded, frame restarts at (0,0)
    do_reset();
    send_pixels(0, 2 * H + 2, 0, -1);
    check_output("sof_err_before", err_sync, 0);
    check_output("sof_mvalid_before", m_valid, 1);
    apply_stimulus(0, 0, 1, 0, 0);
    check_output("sof_mvalid_drop", m_valid, 0);
    check_output("sof_err_set", err_sync, 1);
    clear_obs();
    send_pixels(1, H * V - 1, 0, -1);
    wait_frame_and_verify();

    // Reset during FLUSH: immediate return to reset values, no frame_done
    do_reset();
    send_pixels(0, H * V - 1, 0, -1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("flushrst_m_valid", m_valid, 0);
    check_output("flushrst_s_ready", s_ready, 0);
    check_output("flushrst_lb_we", lb_we, 0);
    check_output("flushrst_lb_x", lb_x, 0);
    check_output("flushrst_lb_y", lb_y, 0);
    check_output("flushrst_m_x", m_x, 0);
    check_output("flushrst_m_y", m_y, 0);
    check_output("flushrst_border", m_border, 0);
    check_output("flushrst_done", frame_done, 0);
    reset = 1'b0;
    clear_obs();
    repeat (40) @(posedge clk);
    #1;
    check_output("flushrst_no_done", done_cnt, 0);
    check_output("flushrst_no_windows", obs_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
